// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared constants for the push-button conditioner: default
//                timing parameters and the board's button channel indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Default timing: 763 Hz sample tick at 100 MHz, 3-sample stability
    localparam int TICK_DIV_DEFAULT     = 131072;
    localparam int STABLE_TICKS_DEFAULT = 3;
    localparam int REPEAT_DELAY_DEFAULT = 300;
    localparam int REPEAT_RATE_DEFAULT  = 50;

    // Channel positions on the btn bus
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    // Larger of two integers, for sizing shared counters at elaboration
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running divider producing a one-cycle strobe every
//                TICK_DIV clock cycles. The strobe is high exactly in the
//                cycle where the divider sits at its terminal value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import btn_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(TICK_DIV - 1);
    // Tick is registered, so it is loaded one count ahead of the terminal value
    localparam logic [DIV_W-1:0] C_DIV_PRE  = DIV_W'(TICK_DIV - 2);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;

    // Divider wraps at TICK_DIV-1; tick tracks (r_div == C_DIV_LAST) registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_div == C_DIV_LAST) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            r_tick <= (r_div == C_DIV_PRE);
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/multi_btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_btn_debouncer
//  Description : N-channel push-button conditioner. Two-flop synchroniser,
//                shared low-rate sample tick, per-channel consecutive-sample
//                stability filter with registered level, press and release
//                outputs. Define AUTO_REPEAT_EN to build held-button
//                auto-repeat on btn_press.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_btn_debouncer
    import btn_pkg::*;
#(
    parameter int N_CH         = 5,
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic            tick
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    // Reject parameter values the counters cannot represent
    if (N_CH < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("multi_btn_debouncer: parameter out of range");
    end

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic            w_tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign tick = w_tick;

    // Two-stage synchroniser for the asynchronous pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_lvl;
        logic             r_prs;
        logic             r_rel;
        logic             w_accept;
        logic             w_rep_pulse;

        // New value has persisted for STABLE_TICKS samples, including this one
        assign w_accept = w_tick && (r_sync2[g] != r_lvl) && (r_cnt == C_CNT_LAST);

`ifdef AUTO_REPEAT_EN
        localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
        localparam logic [REP_W-1:0] C_REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
        localparam logic [REP_W-1:0] C_REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

        logic [REP_W-1:0] r_rep;
        logic             r_rep_fast;   // 0: waiting initial delay, 1: repeating

        // A pending release acceptance wins over a coincident repeat pulse
        assign w_rep_pulse = w_tick && r_lvl && !w_accept &&
                             (r_rep_fast ? (r_rep == C_REP_RATE_LAST)
                                         : (r_rep == C_REP_DELAY_LAST));

        // Held-button tick counter; restarts on every acceptance and while released
        always_ff @(posedge clk) begin
            if (rst || !r_lvl || w_accept) begin
                r_rep      <= '0;
                r_rep_fast <= 1'b0;
            end else if (w_rep_pulse) begin
                r_rep      <= '0;
                r_rep_fast <= 1'b1;
            end else if (w_tick) begin
                r_rep      <= r_rep + REP_W'(1);
            end
        end
`else
        assign w_rep_pulse = 1'b0;
`endif

        // Stability filter: count mismatching samples, toggle level on the last
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
                r_prs <= 1'b0;
                r_rel <= 1'b0;
            end else begin
                r_prs <= (w_accept && !r_lvl) || w_rep_pulse;
                r_rel <= w_accept && r_lvl;
                if (w_tick) begin
                    if (r_sync2[g] == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_cnt <= '0;
                        r_lvl <= ~r_lvl;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end

        assign btn_level[g]   = r_lvl;
        assign btn_press[g]   = r_prs;
        assign btn_release[g] = r_rel;
    end

endmodule
`default_nettype wire
